pool_stream_unit: RTL and testbench

Streaming multi-channel K×K pooling unit, successor to the fixed 2×2 one-shot max-pool array. Accepts one pixel per cycle (all channels in parallel) in raster order over an IMG_W×IMG_H feature map. It accumulates non-overlapping K×K windows in a column line buffer and emits one pooled pixel per window through a valid/ready handshake with backpressure. It sits between a conv layer output and the next layer input; max and average modes are supported.

---
 rtl/pool_pkg.sv | 25 ++
 rtl/pool_combine.sv | 48 ++++
 rtl/pool_stream_unit.sv | 159 +++++++++++++++
 tb/tb_pool_stream_unit.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pool_pkg.sv
// Shared types and width helpers for the streaming pooling unit.
// POOL_AVG_EN widens the accumulators for average mode; otherwise they stay BITS wide.
package pool_pkg;

  localparam logic POOL_MAX = 1'b0;
  localparam logic POOL_AVG = 1'b1;

  typedef enum logic {
    S_IDLE,
    S_RUN
  } pool_state_e;

  function automatic int pool_log2k(input int k);
    return (k == 4) ? 2 : 1;
  endfunction

  function automatic int pool_aw(input int bits, input int k);
`ifdef POOL_AVG_EN
    return bits + 2 * pool_log2k(k);
`else
    return bits;
`endif
  endfunction

endpackage

// File: rtl/pool_combine.sv
// One channel of the window datapath: load, max/sum combine, and the emitted result.
// With POOL_AVG_EN undefined only the signed maximum exists and mode is ignored.
module pool_combine
  import pool_pkg::*;
#(
  parameter int BITS   = 16,
  parameter int POOL_K = 2,
  parameter int AW     = pool_aw(BITS, POOL_K)
) (
  input  logic            mode,
  input  logic            load,
  input  logic [AW-1:0]   acc_i,
  input  logic [BITS-1:0] pix_i,
  output logic [AW-1:0]   acc_o,
  output logic [BITS-1:0] res_o
);

  logic signed [AW-1:0] acc_s;
  logic signed [AW-1:0] pix_s;
  logic signed [AW-1:0] max_s;
  logic signed [AW-1:0] comb_s;

`ifdef POOL_AVG_EN
  localparam int SHIFT = 2 * pool_log2k(POOL_K);
  logic signed [AW-1:0] sum_s;
`else
  logic unused_mode;
  assign unused_mode = mode;
`endif

  always_comb begin
    acc_s  = $signed(acc_i);
    pix_s  = AW'($signed(pix_i));
    max_s  = (pix_s > acc_s) ? pix_s : acc_s;
    comb_s = max_s;
    res_o  = BITS'(max_s);
`ifdef POOL_AVG_EN
    sum_s  = acc_s + pix_s;
    if (mode == POOL_AVG) begin
      comb_s = sum_s;
      // Arithmetic shift floors toward -inf; K*K values of BITS always fit AW.
      res_o  = BITS'(sum_s >>> SHIFT);
    end
`endif
    acc_o = load ? pix_s : comb_s;
  end

endmodule

// File: rtl/pool_stream_unit.sv
// Streaming K x K non-overlapping pooling over a raster feature map, valid/ready on both sides.
// Average mode is compiled in only when POOL_AVG_EN is defined.
module pool_stream_unit
  import pool_pkg::*;
#(
  parameter int BITS   = 16,
  parameter int CH     = 8,
  parameter int IMG_W  = 24,
  parameter int IMG_H  = 24,
  parameter int POOL_K = 2
) (
  input  logic               clk_in,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               mode,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [CH*BITS-1:0] in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [CH*BITS-1:0] out_data,
  output logic               out_last
);

  localparam int AW = pool_aw(BITS, POOL_K);
  localparam int LK = pool_log2k(POOL_K);
  localparam int NG = IMG_W / POOL_K;
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int GW = (CW > LK) ? CW - LK : 1;

  if (!(POOL_K == 2 || POOL_K == 4) || (IMG_W % POOL_K) != 0 || (IMG_H % POOL_K) != 0)
  begin : g_bad_cfg
    $error("pool_stream_unit: POOL_K must be 2 or 4 and divide IMG_W and IMG_H");
  end

  // Handshake: a beat moves on a side only in a cycle where its valid and ready are both high.
  pool_state_e         state_q, state_d;
  logic [CW-1:0]       col_q, col_d;
  logic [RW-1:0]       row_q, row_d;
  logic                out_valid_q, out_valid_d;
  logic [CH*BITS-1:0]  out_data_q, out_data_d;
  logic                out_last_q, out_last_d;

  logic                accept, load_win, emit_win, last_pix, lb_we, mode_eff;
  logic [LK-1:0]       r_idx, c_idx;
  logic [GW-1:0]       g_idx;
  logic [CH*AW-1:0]    lb_q [NG];
  logic [CH*AW-1:0]    lb_rd, lb_wr;
  logic [CH*BITS-1:0]  res_flat;

  assign r_idx = row_q[LK-1:0];
  assign c_idx = col_q[LK-1:0];
  assign g_idx = GW'(col_q >> LK);
  assign lb_rd = lb_q[g_idx];

`ifdef POOL_AVG_EN
  logic mode_q, mode_d;
  // The first pixel of a frame must already see the mode it latches.
  assign mode_eff = (state_q == S_IDLE) ? mode : mode_q;

  always_comb begin
    mode_d = mode_q;
    if (accept && state_q == S_IDLE) mode_d = mode;
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) mode_q <= POOL_MAX;
    else        mode_q <= mode_d;
  end
`else
  logic unused_mode;
  assign unused_mode = mode;
  assign mode_eff    = POOL_MAX;
`endif

  for (genvar ch = 0; ch < CH; ch++) begin : g_ch
    pool_combine #(
      .BITS   (BITS),
      .POOL_K (POOL_K),
      .AW     (AW)
    ) u_combine (
      .mode  (mode_eff),
      .load  (load_win),
      .acc_i (lb_rd[ch*AW +: AW]),
      .pix_i (in_data[ch*BITS +: BITS]),
      .acc_o (lb_wr[ch*AW +: AW]),
      .res_o (res_flat[ch*BITS +: BITS])
    );
  end

  always_comb begin
    in_ready    = !clear && (!out_valid_q || out_ready);
    accept      = in_valid && in_ready;
    load_win    = (r_idx == '0) && (c_idx == '0);
    emit_win    = (r_idx == LK'(POOL_K - 1)) && (c_idx == LK'(POOL_K - 1));
    last_pix    = (row_q == RW'(IMG_H - 1)) && (col_q == CW'(IMG_W - 1));
    lb_we       = accept && !emit_win;

    state_d     = state_q;
    col_d       = col_q;
    row_d       = row_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;

    if (out_valid_q && out_ready) out_valid_d = 1'b0;

    if (clear) begin
      state_d     = S_IDLE;
      col_d       = '0;
      row_d       = '0;
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end else if (accept) begin
      if (state_q == S_IDLE) state_d = S_RUN;
      if (emit_win) begin
        out_valid_d = 1'b1;
        out_data_d  = res_flat;
        out_last_d  = last_pix;
      end
      if (col_q == CW'(IMG_W - 1)) begin
        col_d = '0;
        row_d = last_pix ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
      if (last_pix) state_d = S_IDLE;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      col_q       <= '0;
      row_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
    end
  end

  // Line buffer entries are always loaded before use, so they carry no reset.
  always_ff @(posedge clk_in) begin
    if (lb_we) lb_q[g_idx] <= lb_wr;
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_pool_stream_unit.sv
// Randomized scoreboard bench for pool_stream_unit on a 4x4, 2-channel, K=2 map.
// Expected windows come from a plain max / floor-average model over the stored frame.
module tb_pool_stream_unit;

  localparam int BITS = 16;
  localparam int CH   = 2;
  localparam int W    = 4;
  localparam int H    = 4;
  localparam int K    = 2;
  localparam int DW   = CH * BITS;
  localparam int EW   = DW + 1;

  logic          clk_in = 1'b0;
  logic          rst_n;
  logic          clear;
  logic          mode;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_last;

  logic [EW-1:0] exp_q[$];
  int            vectors     = 0;
  int            miscompares = 0;
  int            fpix [H][W][CH];
  bit            bp_rand     = 1'b0;

  pool_stream_unit #(
    .BITS   (BITS),
    .CH     (CH),
    .IMG_W  (W),
    .IMG_H  (H),
    .POOL_K (K)
  ) dut (
    .clk_in    (clk_in),
    .rst_n     (rst_n),
    .clear     (clear),
    .mode      (mode),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last)
  );

  // clock / watchdog
  always #5 clk_in = ~clk_in;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // reference model
  function automatic int floor_div(input int s, input int d);
    int q;
    q = s / d;
    if ((s % d) != 0 && s < 0) q = q - 1;
    return q;
  endfunction

  task automatic push_expected(input bit mode_v);
    bit            avg;
    int            m, s, v, r;
    logic [31:0]   rv;
    logic [DW-1:0] d;
    logic          last;
`ifdef POOL_AVG_EN
    avg = mode_v;
`else
    avg = 1'b0;
`endif
    for (int wy = 0; wy < H / K; wy++) begin
      for (int wx = 0; wx < W / K; wx++) begin
        for (int ch = 0; ch < CH; ch++) begin
          m = fpix[wy*K][wx*K][ch];
          s = 0;
          for (int dy = 0; dy < K; dy++) begin
            for (int dx = 0; dx < K; dx++) begin
              v = fpix[wy*K+dy][wx*K+dx][ch];
              if (v > m) m = v;
              s += v;
            end
          end
          r  = avg ? floor_div(s, K * K) : m;
          rv = r;
          d[ch*BITS +: BITS] = rv[BITS-1:0];
        end
        last = (wy == H / K - 1) && (wx == W / K - 1);
        exp_q.push_back({last, d});
      end
    end
  endtask

  // kind 0: ramp row*W+col, 1: random, 2: random with first window {-1,-2,-2,-2}
  task automatic fill_frame(input int kind);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        for (int ch = 0; ch < CH; ch++)
          fpix[r][c][ch] = (kind == 0) ? r * W + c : int'($urandom_range(0, 65535)) - 32768;
    if (kind == 2) begin
      for (int ch = 0; ch < CH; ch++) begin
        fpix[0][0][ch] = -1;
        fpix[0][1][ch] = -2;
        fpix[1][0][ch] = -2;
        fpix[1][1][ch] = -2;
      end
    end
  endtask

  // driver tasks: inputs change 1 time unit after the rising edge
  task automatic send_pixel(input int r, input int c);
    logic [31:0]   t;
    logic [DW-1:0] d;
    bit            ok;
    int            n;
    if (bp_rand) begin
      repeat ($urandom_range(0, 1)) begin
        out_ready = ($urandom_range(0, 3) != 0);
        @(posedge clk_in); #1;
      end
    end
    for (int ch = 0; ch < CH; ch++) begin
      t = fpix[r][c][ch];
      d[ch*BITS +: BITS] = t[BITS-1:0];
    end
    in_data  = d;
    in_valid = 1'b1;
    ok = 1'b0;
    n  = 0;
    while (!ok && n < 100) begin
      if (bp_rand) out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk_in);
      ok = in_ready;
      @(posedge clk_in); #1;
      n++;
    end
    in_valid = 1'b0;
    check("in_accept", ok, 1);
  endtask

  task automatic send_frame(input bit mode_v, input bit flip_mode);
    push_expected(mode_v);
    mode = mode_v;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        send_pixel(r, c);
        if (r == 0 && c == 0 && flip_mode) mode = ~mode_v;
      end
    end
  endtask

  task automatic drain();
    int n;
    out_ready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk_in); #1;
      n++;
    end
    check("drain_empty", exp_q.size(), 0);
  endtask

  // scoreboard monitor: a transfer happens at the next rising edge
  always @(negedge clk_in) begin
    logic [EW-1:0] e;
    if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_output: got %0h, required no output", out_data);
      end else begin
        e = exp_q.pop_front();
        check("out_data", out_data, e[DW-1:0]);
        check("out_last", out_last, e[DW]);
      end
    end
  end

  initial begin
    logic [DW-1:0] hold_data;
    int            n;

    rst_n     = 1'b0;
    clear     = 1'b0;
    mode      = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;

    repeat (3) @(negedge clk_in);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_last", out_last, 0);
    check("rst_in_ready", in_ready, 1);
    @(posedge clk_in); #1;
    rst_n = 1'b1;
    @(negedge clk_in);
    check("post_rst_in_ready", in_ready, 1);
    @(posedge clk_in); #1;

    // ramp, max then average, then the floor window
    fill_frame(0); send_frame(1'b0, 1'b0); drain();
    fill_frame(0); send_frame(1'b1, 1'b0); drain();
    fill_frame(2); send_frame(1'b1, 1'b0); drain();

    // backpressure at the first output
    fill_frame(0);
    out_ready = 1'b0;
    fork
      send_frame(1'b0, 1'b0);
      begin
        n = 0;
        while (out_valid !== 1'b1 && n < 50) begin
          @(negedge clk_in);
          n++;
        end
        check("bp_valid_seen", out_valid, 1);
        hold_data = exp_q[0][DW-1:0];
        for (int i = 0; i < 5; i++) begin
          @(negedge clk_in);
          check("bp_in_ready", in_ready, 0);
          check("bp_valid_hold", out_valid, 1);
          check("bp_data_hold", out_data, hold_data);
          check("bp_last_hold", out_last, 0);
        end
        @(posedge clk_in); #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // clear with in_valid while an output is pending
    fill_frame(0);
    mode = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) send_pixel(i / W, i % W);
    @(negedge clk_in);
    check("clr_pending", out_valid, 1);
    @(posedge clk_in); #1;
    clear    = 1'b1;
    in_valid = 1'b1;
    in_data  = DW'($urandom);
    @(negedge clk_in);
    check("clr_in_ready", in_ready, 0);
    @(posedge clk_in); #1;
    clear    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk_in);
    check("clr_out_valid", out_valid, 0);
    @(posedge clk_in); #1;
    out_ready = 1'b1;
    fill_frame(1); send_frame(1'b1, 1'b0); drain();

    // asynchronous reset mid-frame, then a fresh frame
    fill_frame(0);
    for (int i = 0; i < 3; i++) send_pixel(0, i);
    rst_n = 1'b0;
    @(negedge clk_in);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 1);
    @(posedge clk_in); #1;
    rst_n = 1'b1;
    fill_frame(0); send_frame(1'b0, 1'b0); drain();

    // random frames with random gaps, backpressure and a mode flip after the first pixel
    bp_rand = 1'b1;
    for (int f = 0; f < 6; f++) begin
      fill_frame(1);
      send_frame(1'($urandom_range(0, 1)), 1'b1);
      drain();
    end
    bp_rand = 1'b0;

    repeat (3) @(posedge clk_in);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
